// File: rtl/led_pattern_gen.sv
// LED pattern generator: one-hot SW selects static/rotate/alternate/bounce patterns, SPEED scales the tick rate.
// Optional define SW_SYNC_EN inserts a 2-flop synchroniser on SW ahead of the mode decode.
module led_pattern_gen #(
    parameter int LED_W    = 8,
    parameter int DIV_W    = 24,
    parameter int TICK_DIV = 2**24
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       SW,
    input  logic [1:0]       SPEED,
    output logic [LED_W-1:0] LED,
    output logic             TICK
);

    typedef enum logic [2:0] {
        M_IDLE,
        M_STATIC,
        M_ROTL,
        M_ROTR,
        M_ALT,
        M_BOUNCE
    } mode_t;

    localparam logic [DIV_W:0] TD = (DIV_W+1)'(TICK_DIV);

    logic [4:0]       w_sw;
    mode_t            w_mode_dec;
    logic [LED_W-1:0] w_alt_seed;
    logic [LED_W-1:0] w_seed;
    logic [DIV_W:0]   w_last;
    logic             w_wrap;

    mode_t            r_mode;
    logic [DIV_W-1:0] r_count;
    logic [LED_W-1:0] r_pat;
    logic             r_dir;
    logic [LED_W-1:0] r_led;
    logic             r_tick;

    mode_t            w_mode_next;
    logic [DIV_W-1:0] w_count_next;
    logic [LED_W-1:0] w_pat_next;
    logic             w_dir_next;
    logic [LED_W-1:0] w_led_next;
    logic             w_tick_next;

`ifdef SW_SYNC_EN
    logic [4:0] r_sw_meta;
    logic [4:0] r_sw_sync;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign w_sw = r_sw_sync;
`else
    assign w_sw = SW;
`endif

    always_comb begin
        case (w_sw)
            5'b00001: w_mode_dec = M_STATIC;
            5'b00010: w_mode_dec = M_ROTL;
            5'b00100: w_mode_dec = M_ROTR;
            5'b01000: w_mode_dec = M_ALT;
            5'b10000: w_mode_dec = M_BOUNCE;
            default:  w_mode_dec = M_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_alt_seed
            assign w_alt_seed[gi] = ((gi % 2) == 0);
        end
    endgenerate

    always_comb begin
        case (w_mode_dec)
            M_IDLE:  w_seed = '0;
            M_ALT:   w_seed = w_alt_seed;
            default: w_seed = LED_W'(1);
        endcase
    end

    // Wrapping on >= rather than == lets a faster SPEED take effect immediately.
    assign w_last = (TD >> SPEED) - (DIV_W+1)'(1);
    assign w_wrap = ({1'b0, r_count} >= w_last);

    always_comb begin
        w_mode_next  = r_mode;
        w_count_next = r_count;
        w_pat_next   = r_pat;
        w_dir_next   = r_dir;
        w_led_next   = r_led;
        w_tick_next  = 1'b0;
        if (w_mode_dec != r_mode) begin
            w_mode_next  = w_mode_dec;
            w_count_next = '0;
            w_pat_next   = w_seed;
            w_dir_next   = 1'b0;
            w_led_next   = '0;
        end else if (r_mode == M_IDLE) begin
            w_count_next = '0;
            w_pat_next   = '0;
            w_led_next   = '0;
        end else begin
            if (r_count == '0) begin
                w_led_next  = r_pat;
                w_tick_next = 1'b1;
                case (r_mode)
                    M_ROTL: w_pat_next = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
                    M_ROTR, M_ALT: w_pat_next = {r_pat[0], r_pat[LED_W-1:1]};
                    M_BOUNCE: begin
                        // r_dir: 0 = moving toward MSB, 1 = moving toward LSB
                        if (!r_dir && r_pat[LED_W-1]) begin
                            w_dir_next = 1'b1;
                            w_pat_next = r_pat >> 1;
                        end else if (r_dir && r_pat[0]) begin
                            w_dir_next = 1'b0;
                            w_pat_next = r_pat << 1;
                        end else begin
                            w_pat_next = r_dir ? (r_pat >> 1) : (r_pat << 1);
                        end
                    end
                    default: w_pat_next = r_pat;
                endcase
            end
            w_count_next = w_wrap ? '0 : r_count + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mode  <= M_IDLE;
            r_count <= '0;
            r_pat   <= '0;
            r_dir   <= 1'b0;
            r_led   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_mode  <= w_mode_next;
            r_count <= w_count_next;
            r_pat   <= w_pat_next;
            r_dir   <= w_dir_next;
            r_led   <= w_led_next;
            r_tick  <= w_tick_next;
        end
    end

    assign LED  = r_led;
    assign TICK = r_tick;

endmodule
